mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Burst sequencer directly upstream of the 256x16 memory DUT.
- Accepts one burst command (start address, beat count, direction) and splits it into single-word memory transactions on the memory valid/ready port.
- Address increments by one per beat.
- Write data is pulled from an upstream stream; read data is pushed to a downstream stream with a last-beat marker.

Parameters:
- WIDTH, 16, data width.
- ADDR_WIDTH, 8, address width.
- DEPTH, 256, memory depth; must equal 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_wr_rd_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_len_i  in  ADDR_WIDTH  beat count minus 1 (0..255 gives 1..256 beats).
- wr_valid_i  in  1  write data valid.
- wr_ready_o  out  1  write data accepted.
- wr_data_i  in  WIDTH  write data.
- rd_valid_o  out  1  read data valid, one cycle per beat.
- rd_data_o  out  WIDTH  read data.
- rd_last_o  out  1  final beat of read burst.
- done_o  out  1  one-cycle pulse on burst completion.
- addr_o  out  ADDR_WIDTH  memory address (to DUT addr_i).
- wdata_o  out  WIDTH  memory write data (to DUT wdata_i).
- wr_rd_o  out  1  memory direction (to DUT wr_rd_i).
- valid_o  out  1  memory request valid (to DUT valid_i).
- mem_rdata_i  in  WIDTH  memory read data (from DUT rdata_o).
- mem_ready_i  in  1  memory ready (from DUT ready_o).

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o = 1. State = IDLE, holding register empty.
- Memory handshake: a beat transfers on the posedge where valid_o && mem_ready_i. For reads, mem_rdata_i is valid in that same cycle.
- Stability: valid_o, addr_o, wdata_o and wr_rd_o are register-driven and hold stable from valid_o rise until the handshake. There is no combinational path from mem_ready_i to any memory-side output.
- State machine, IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch addr, len and direction into beat counter, address register and dir register; go to ACTIVE.
- State machine, ACTIVE:
  - cmd_ready_o = 0.
  - Read: valid_o rises the cycle after command acceptance and stays high until the last handshake. Back-to-back beats are allowed: valid_o stays high while mem_ready_i is high.
  - Write: wr_ready_o = ACTIVE && wr direction && holding register empty. A word accepted at edge N sets hold_full; valid_o is high in cycle N+1. Holding register clears on handshake. Maximum one beat per 2 cycles unless the holding register reloads on the handshake edge (permitted: wr_ready_o may also be high when handshake occurs in the same cycle only if computed from registered state — otherwise not).
- Per handshake:
  - addr register increments modulo DEPTH; 255 wraps to 0.
  - Beat counter decrements.
  - Read beats: rd_valid_o = 1 and rd_data_o = mem_rdata_i on the following cycle (1-cycle latency). rd_last_o is set with the final beat. The consumer cannot stall.
- Final handshake (counter == 0): return to IDLE. done_o pulses in the next cycle; for reads this is coincident with the last rd_valid_o. The next command is accepted no earlier than the cycle after the return to IDLE.
- Command held while ACTIVE: ignored, cmd_ready_o = 0.
- wr_valid_i during a read burst or in IDLE: ignored, wr_ready_o = 0.
- Reset mid-burst: immediate return to reset values. valid_o drops asynchronously, the partial burst is abandoned, and no done_o is produced.

Optional Feature:
- Macro: MEM_BURST_BOUND_CHECK_EN.
- Defined:
  - Adds port err_o (out, 1).
  - A command with cmd_addr_i + cmd_len_i > DEPTH-1 is accepted (cmd_ready_o handshake) but produces no memory transactions.
  - err_o and done_o pulse together one cycle after acceptance; state stays IDLE.
- Undefined: no err_o port; addresses wrap modulo DEPTH.

Decomposition:
- Package mem_pkg holds:
  - WIDTH, DEPTH and ADDR_WIDTH constants.
  - typedef enum logic {IDLE, ACTIVE} burst_state_t.
  - typedef struct packed {wr_rd, addr, len} burst_cmd_t.
- No sub-module. The write holding register and beat counter are inline; the block is a single FSM plus datapath.

Test Plan:
- Read burst: addr=0x10, len=3, mem_ready_i tied 1, memory returns 0xA000+addr → 4 handshakes on addrs 0x10..0x13. rd_data_o = 0xA010..0xA013 on consecutive cycles; rd_last_o and done_o on the 4th.
- Write burst: addr=0x20, len=1, data 0x1234/0x5678, ready held low 3 cycles per beat → valid_o/addr_o/wdata_o stay stable while stalled. Writes land at 0x20 and 0x21; done_o pulses once.
- Wrap-around: read addr=0xFE, len=3 → addrs 0xFE, 0xFF, 0x00, 0x01. With MEM_BURST_BOUND_CHECK_EN defined: no valid_o; err_o=1 and done_o=1 one cycle after acceptance.
- Maximum burst: len=0xFF write → exactly 256 handshakes; addr ends at start-1 mod 256; cmd_ready_o low for the whole burst.
- Reset mid-burst: assert rst_i after the 2nd of 8 read beats → valid_o=0 immediately, no done_o. A new command len=0 after reset completes in one beat.
- Back-pressure on write input: wr_valid_i gaps of 5 cycles → valid_o is low during gaps and no spurious handshakes occur.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory burst sequencer.
//
// Contents:
//   WIDTH, ADDR_WIDTH, DEPTH  - memory geometry (256 x 16)
//   burst_state_t             - sequencer FSM state
//   burst_cmd_t               - one burst command (direction, start address, beats - 1)
package mem_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    ACTIVE
  } burst_state_t;

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] len;
  } burst_cmd_t;

endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a single-port 256x16 memory.
//
// Accepts one burst command (start address, beat count - 1, direction) and issues one
// single-word valid/ready transaction per beat, incrementing the address modulo DEPTH.
// Write data is pulled from an upstream valid/ready stream through a one-word holding
// register; read data is returned one cycle after each handshake with a last-beat flag.
//
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o              burst command handshake
//   cmd_wr_rd_i, cmd_addr_i, cmd_len_i   direction (1 = write), start address, beats - 1
//   wr_valid_i/wr_ready_o, wr_data_i     upstream write data stream
//   rd_valid_o, rd_data_o, rd_last_o     downstream read data stream (cannot stall)
//   done_o                               one-cycle pulse when a burst completes
//   addr_o, wdata_o, wr_rd_o, valid_o    memory request (all register-driven)
//   mem_rdata_i, mem_ready_i             memory response
//   err_o                                only with MEM_BURST_BOUND_CHECK_EN: pulses with
//                                        done_o when a command would cross the top of memory
//
// Build option:
//   MEM_BURST_BOUND_CHECK_EN  reject (no transactions, err_o + done_o) any command with
//                             cmd_addr_i + cmd_len_i > DEPTH - 1. Undefined: addresses wrap.
module mem_burst_ctrl #(
  parameter int unsigned WIDTH      = mem_pkg::WIDTH,
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH      = mem_pkg::DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_last_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i
`ifdef MEM_BURST_BOUND_CHECK_EN
  ,
  output logic                  err_o
`endif
);

  import mem_pkg::*;

  burst_state_t          state_q;
  burst_cmd_t            cmd;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;     // beats remaining after the current one
  logic                  dir_q;
  logic                  valid_q;
  logic                  hold_full_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  rd_valid_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  rd_last_q;
  logic                  done_q;
  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  mem_fire;
  logic                  last_beat;
  logic                  cmd_oob;

  assign cmd = {cmd_wr_rd_i, cmd_addr_i, cmd_len_i};

  assign cmd_ready_o = (state_q == IDLE);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  // Holding register only refills once the previous word has been handed to memory.
  assign wr_ready_o  = (state_q == ACTIVE) && dir_q && !hold_full_q;
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign mem_fire    = valid_q && mem_ready_i;
  assign last_beat   = (cnt_q == '0);

`ifdef MEM_BURST_BOUND_CHECK_EN
  logic [ADDR_WIDTH:0] cmd_end;
  logic                err_q;

  // One extra bit so the sum cannot wrap before the comparison.
  assign cmd_end = {1'b0, cmd.addr} + {1'b0, cmd.len};
  assign cmd_oob = cmd_end > (ADDR_WIDTH + 1)'(DEPTH - 1);
  assign err_o   = err_q;
`else
  assign cmd_oob = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      hold_full_q <= 1'b0;
      wdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_BURST_BOUND_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_BURST_BOUND_CHECK_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_oob) begin
              done_q <= 1'b1;
`ifdef MEM_BURST_BOUND_CHECK_EN
              err_q  <= 1'b1;
`endif
            end else begin
              state_q <= ACTIVE;
              dir_q   <= cmd.wr_rd;
              addr_q  <= cmd.addr;
              cnt_q   <= cmd.len;
              // Reads request immediately; writes wait for the first data word.
              valid_q <= !cmd.wr_rd;
            end
          end
        end
        ACTIVE: begin
          if (wr_fire) begin
            wdata_q     <= wr_data_i;
            hold_full_q <= 1'b1;
            valid_q     <= 1'b1;
          end
          if (mem_fire) begin
            addr_q      <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            cnt_q       <= cnt_q - 1'b1;
            hold_full_q <= 1'b0;
            if (!dir_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem_rdata_i;
              rd_last_q  <= last_beat;
            end
            if (last_beat) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (dir_q) begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign wr_rd_o    = dir_q;
  assign valid_o    = valid_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign done_o     = done_q;

endmodule
